adder_pipe_acc: RTL and testbench
=================================

// Module: adder_pipe_acc
// PURPOSE
//  Parametrised pipelined adder/subtractor/accumulator; successor to the 4-bit ripple adder.
//  Carry chain is split into STAGES register slices so WIDTH can grow without a long ripple path.
//  valid/ready on both sides; sits between the input register bank and the result mux.
// PARAMETERS
//  WIDTH   8  operand/result width in bits; must be a multiple of STAGES
//  STAGES  2  pipeline depth (carry slices), 1..WIDTH; slice width SW = WIDTH/STAGES
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      synchronous active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat this cycle
//  op         in   2      00 ADD a+b+cin, 01 SUB a-b, 10 ACC acc+a, 11 reserved (treated as ADD)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (ignored for ACC)
//  cin        in   1      carry in for ADD only; ignored for SUB/ACC
//  acc_clr    in   1      clear accumulator to 0
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out (SUB: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
//  sat        out  1      result was clamped (ADDER_SAT_EN only, else 0)
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid 0, sum 0, cout 0, ovf 0, sat 0, acc 0; in-flight beats dropped.
//  - Transfer at input when in_valid&in_ready; at output when out_valid&out_ready.
//  - adv = !out_valid | out_ready; all stages shift together when adv, hold when !adv (no bubble collapse).
//  - in_ready = adv & !acc_busy; acc_busy = any ACC beat in stages 0..STAGES-1.
//  - Stage k adds slice k (bits k*SW+SW-1..k*SW) with carry from stage k-1; higher slices ride
//    along unregistered-math; lower result slices ride along. Latency = STAGES cycles, no stall.
//  - SUB: B operand = ~b, carry in = 1. ACC: B operand = acc, carry in = 0.
//  - cout = carry out of MSB slice; ovf = (A[MSB]==B'[MSB]) & (sum[MSB]!=A[MSB]) with B' as applied.
//  - acc <= sum when an ACC result transfers at output; at most one ACC in flight, so no hazard.
//  - acc_clr: acc <= 0 next cycle; if same cycle as ACC output transfer, clear wins.
//  - acc_clr does not affect an ACC beat already in flight (it used the old acc).
//  - Result registers and flags hold while out_valid & !out_ready.
//  - Bubbles (stage valid 0) propagate; data in empty stages is don't-care, flags only meaningful
//    with out_valid.
//  - Back-to-back ADD/SUB: throughput 1 beat/cycle; ACC: 1 beat per STAGES+ cycles.
// CONFIGURATION
//  ADDER_SAT_EN defined: unsigned saturation applied in final stage:
//   ADD/ACC with cout=1 -> sum = all ones, sat=1; SUB with cout=0 -> sum = 0, sat=1;
//   cout/ovf still report the unclamped result; acc loads the clamped sum.
//  ADDER_SAT_EN undefined: results wrap modulo 2^WIDTH, sat tied 0, no saturation logic.
// TESTING (WIDTH=8, STAGES=2 unless noted)
//  - ADD a=3C b=5A cin=0 -> 2 cycles later sum=96 cout=0 ovf=1; a=FF b=02 -> sum=01 cout=1
//    (SAT_EN: FF sat=1).
//  - SUB a=10 b=20 -> sum=F0 cout=0 ovf=0 (SAT_EN: sum=00 sat=1); a=20 b=10 -> 10 cout=1.
//  - acc_clr, then ACC a=10 x3 -> sums 10,20,30; in_ready low while each ACC in flight.
//  - Stream 8 ADD beats, out_ready low cycles 3-5 -> no loss/dup, order kept, in_ready=0 when full.
//  - rst mid-stream with 2 beats in flight -> next cycle out_valid=0, acc=0, in_ready=1.
//  - Sweep WIDTH=16 STAGES=4 and STAGES=1 -> random ADD/SUB vs golden model, latency=STAGES.

Source files
------------

// File: rtl/adder_pipe_acc.sv
// Pipelined add/sub/accumulate unit: the carry chain is cut into STAGES register slices.
// Optional unsigned saturation in the final slice is enabled by defining ADDER_SAT_EN.
module adder_pipe_acc #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sat
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned MSB  = WIDTH - 1;
    localparam int unsigned LAST = STAGES - 1;

    typedef enum logic [1:0] {
        OpAdd = 2'b00,
        OpSub = 2'b01,
        OpAcc = 2'b10,
        OpRsv = 2'b11
    } op_e;

    // One pipeline slot: operands as applied, partial result, carry into the next slice.
    typedef struct packed {
        logic             valid;
        logic             is_acc;
        logic             is_sub;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             sat;
    } stage_t;

    stage_t           stage_q  [STAGES];
    stage_t           stage_d  [STAGES];
    stage_t           stage_in [STAGES];
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic             adv;
    logic             acc_busy;
    op_e              op_dec;

    assign op_dec = op_e'(op);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign out_valid = stage_q[LAST].valid;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv && !acc_busy;

    always_comb begin
        acc_busy = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (stage_q[k].valid && stage_q[k].is_acc) begin
                acc_busy = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand preparation and stage inputs
    // ------------------------------------------------------------------
    always_comb begin
        stage_in[0]        = '0;
        stage_in[0].valid  = in_valid && in_ready;
        stage_in[0].is_acc = (op_dec == OpAcc);
        stage_in[0].is_sub = (op_dec == OpSub);
        stage_in[0].opa    = a;
        case (op_dec)
            OpSub: begin
                stage_in[0].opb   = ~b;
                stage_in[0].carry = 1'b1;
            end
            OpAcc: begin
                stage_in[0].opb   = acc_q;
                stage_in[0].carry = 1'b0;
            end
            default: begin
                stage_in[0].opb   = b;
                stage_in[0].carry = cin;
            end
        endcase
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Slice adders; the final slice also derives flags and optional clamp
    // ------------------------------------------------------------------
    always_comb begin
        logic [SW:0] slice;
        slice = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = stage_in[k];
            slice = {1'b0, stage_in[k].opa[k*SW +: SW]}
                  + {1'b0, stage_in[k].opb[k*SW +: SW]}
                  + {{SW{1'b0}}, stage_in[k].carry};
            stage_d[k].res[k*SW +: SW] = slice[SW-1:0];
            stage_d[k].carry           = slice[SW];
        end

        // Flags reflect the unclamped result.
        stage_d[LAST].ovf = (stage_d[LAST].opa[MSB] == stage_d[LAST].opb[MSB])
                         && (stage_d[LAST].res[MSB] != stage_d[LAST].opa[MSB]);
        stage_d[LAST].sat = 1'b0;
`ifdef ADDER_SAT_EN
        if (!stage_d[LAST].is_sub && stage_d[LAST].carry) begin
            stage_d[LAST].res = '1;
            stage_d[LAST].sat = 1'b1;
        end else if (stage_d[LAST].is_sub && !stage_d[LAST].carry) begin
            stage_d[LAST].res = '0;
            stage_d[LAST].sat = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Pipeline registers: every slot shifts on adv, holds otherwise
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q[k] <= '0;
            end else if (adv) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    always_comb begin
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else if (out_valid && out_ready && stage_q[LAST].is_acc) begin
            acc_d = stage_q[LAST].res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sum  = stage_q[LAST].res;
    assign cout = stage_q[LAST].carry;
    assign ovf  = stage_q[LAST].ovf;
    assign sat  = stage_q[LAST].sat;

    // Operand copies in the output slot are not needed past the last slice.
    logic unused_out;
    assign unused_out = ^{stage_q[LAST].opa, stage_q[LAST].opb, stage_q[LAST].is_sub};

endmodule

// File: tb/tb_adder_pipe_acc.sv
// Self-checking bench for adder_pipe_acc: directed + random beats on an 8/2 instance,
// random ADD/SUB latency sweep on 16/4 and 16/1 instances.
module tb_adder_pipe_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, cin, acc_clr, out_valid, out_ready;
    logic [1:0] op;
    logic [7:0] a, b, sum;
    logic       cout, ovf, sat;

    logic        in_valid_w, cin_w, acc_clr_w, out_ready_w;
    logic [1:0]  op_w;
    logic [15:0] a_w, b_w;
    logic        in_ready_s4, out_valid_s4, cout_s4, ovf_s4, sat_s4;
    logic [15:0] sum_s4;
    logic        in_ready_s1, out_valid_s1, cout_s1, ovf_s1, sat_s1;
    logic [15:0] sum_s1;

    adder_pipe_acc #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .cin(cin), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .sat(sat)
    );

    adder_pipe_acc #(.WIDTH(16), .STAGES(4)) dut_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_s4), .op(op_w),
        .a(a_w), .b(b_w), .cin(cin_w), .acc_clr(acc_clr_w), .out_valid(out_valid_s4),
        .out_ready(out_ready_w), .sum(sum_s4), .cout(cout_s4), .ovf(ovf_s4), .sat(sat_s4)
    );

    adder_pipe_acc #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_s1), .op(op_w),
        .a(a_w), .b(b_w), .cin(cin_w), .acc_clr(acc_clr_w), .out_valid(out_valid_s1),
        .out_ready(out_ready_w), .sum(sum_s1), .cout(cout_s1), .ovf(ovf_s1), .sat(sat_s1)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint acc_m    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input logic [1:0] o, input longint av,
                                  input longint bv, input logic ci, input longint accv,
                                  output longint s, output logic co, output logic ov,
                                  output logic st);
        longint mask, half, sa, sb, sres, full;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - (mask + 1) : av;
        case (o)
            2'b01: begin
                sb   = (bv >= half) ? bv - (mask + 1) : bv;
                full = av - bv;
                co   = (av >= bv);
                sres = sa - sb;
            end
            2'b10: begin
                sb   = (accv >= half) ? accv - (mask + 1) : accv;
                full = av + accv;
                co   = (full > mask);
                sres = sa + sb;
            end
            default: begin
                sb   = (bv >= half) ? bv - (mask + 1) : bv;
                full = av + bv + longint'(ci);
                co   = (full > mask);
                sres = sa + sb + longint'(ci);
            end
        endcase
        s  = full & mask;
        ov = (sres >= half) || (sres < -half);
        st = 1'b0;
`ifdef ADDER_SAT_EN
        if (o != 2'b01 && co) begin
            s  = mask;
            st = 1'b1;
        end else if (o == 2'b01 && !co) begin
            s  = 0;
            st = 1'b1;
        end
`endif
    endfunction

    // One isolated beat through the 8/2 instance; clr_phase 1 = clear while in flight,
    // 2 = clear in the cycle the result transfers.
    task automatic issue8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int clr_phase, input string tag);
        longint es;
        logic   ec, eo, est;
        model(8, o, longint'(av), longint'(bv), ci, acc_m, es, ec, eo, est);
        @(negedge clk);
        acc_clr = 1'b0; in_valid = 1'b1; op = o; a = av; b = bv; cin = ci; out_ready = 1'b1;
        #1 check({tag, ".accept"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
        acc_clr = (clr_phase == 1);
        #1 check({tag, ".lat"}, 64'(out_valid), 64'd0);
        check({tag, ".busy"}, 64'(in_ready), (o == 2'b10) ? 64'd0 : 64'd1);
        @(negedge clk);
        acc_clr = (clr_phase == 2);
        #1 check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sum"}, 64'(sum), es);
        check({tag, ".cout"}, 64'(cout), 64'(ec));
        check({tag, ".ovf"}, 64'(ovf), 64'(eo));
        check({tag, ".sat"}, 64'(sat), 64'(est));
        if (o == 2'b10) acc_m = (clr_phase == 2) ? 0 : es;
        else if (clr_phase != 0) acc_m = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  q_sum[$];
        logic        q_c[$];
        logic [7:0]  cur_a, cur_b;
        longint      es;
        logic        ec, eo, est;
        int          sent, got, c;
        logic        saw_stall;
        longint      sw_sum[40];
        logic        sw_c[40], sw_o[40], sw_s[40];
        int          idx;

        rst = 1'b1; in_valid = 0; op = 0; a = 0; b = 0; cin = 0; acc_clr = 0; out_ready = 1;
        in_valid_w = 0; op_w = 0; a_w = 0; b_w = 0; cin_w = 0; acc_clr_w = 0; out_ready_w = 1;
        repeat (2) @(negedge clk);
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.sum", 64'(sum), 64'd0);
        check("rst.cout", 64'(cout), 64'd0);
        check("rst.ovf", 64'(ovf), 64'd0);
        check("rst.sat", 64'(sat), 64'd0);
        rst = 1'b0;
        #1 check("rst.ready", 64'(in_ready), 64'd1);

        // Directed ADD/SUB corners
        issue8(2'b00, 8'h3C, 8'h5A, 1'b0, 0, "add_3c_5a");
        issue8(2'b00, 8'hFF, 8'h02, 1'b0, 0, "add_ff_02");
        issue8(2'b00, 8'h7F, 8'h00, 1'b1, 0, "add_cin_ovf");
        issue8(2'b11, 8'h01, 8'h02, 1'b1, 0, "rsv_as_add");
        issue8(2'b01, 8'h10, 8'h20, 1'b1, 0, "sub_10_20");
        issue8(2'b01, 8'h20, 8'h10, 1'b0, 0, "sub_20_10");
        issue8(2'b01, 8'h00, 8'h80, 1'b0, 0, "sub_ovf");

        // Accumulator
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0; acc_m = 0;
        for (int i = 0; i < 3; i++) issue8(2'b10, 8'h10, 8'($urandom), 1'b1, 0, "acc_10");
        issue8(2'b10, 8'h05, 8'h00, 1'b0, 1, "acc_clr_inflight");
        issue8(2'b10, 8'h01, 8'h00, 1'b0, 0, "acc_after_inflight");
        issue8(2'b10, 8'h05, 8'h00, 1'b0, 2, "acc_clr_wins");
        issue8(2'b10, 8'h07, 8'h00, 1'b0, 0, "acc_after_clr");

        // Random mixed beats
        for (int i = 0; i < 24; i++) begin
            issue8(2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, "rand8");
        end

        // Streaming with backpressure
        @(negedge clk); acc_clr = 1'b0;
        sent = 0; got = 0; c = 0; saw_stall = 1'b0;
        cur_a = 8'($urandom); cur_b = 8'($urandom);
        while (got < 8 && c < 60) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 8);
            op = 2'b00; a = cur_a; b = cur_b; cin = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("stream.full", 64'(in_ready), 64'd0);
                if (in_valid) saw_stall = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q_sum.size() == 0) begin
                    check("stream.extra", 64'(q_sum.size()), 64'd1);
                end else begin
                    check("stream.sum", 64'(sum), 64'(q_sum.pop_front()));
                    check("stream.cout", 64'(cout), 64'(q_c.pop_front()));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                model(8, 2'b00, longint'(cur_a), longint'(cur_b), 1'b0, 0, es, ec, eo, est);
                q_sum.push_back(8'(es));
                q_c.push_back(ec);
                sent++;
                cur_a = 8'($urandom); cur_b = 8'($urandom);
            end
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream.count", 64'(got), 64'd8);
        check("stream.sent", 64'(sent), 64'd8);
        check("stream.stall_seen", 64'(saw_stall), 64'd1);

        // Reset with two beats in flight
        @(negedge clk); acc_clr = 1'b1;
        @(negedge clk); acc_clr = 1'b0; acc_m = 0;
        issue8(2'b10, 8'h44, 8'h00, 1'b0, 0, "acc_pre_rst");
        @(negedge clk); in_valid = 1'b1; op = 2'b00; a = 8'h01; b = 8'h01; out_ready = 1'b0;
        @(negedge clk); a = 8'h02;
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; out_ready = 1'b1;
        #1 check("rstmid.valid", 64'(out_valid), 64'd0);
        check("rstmid.ready", 64'(in_ready), 64'd1);
        acc_m = 0;
        issue8(2'b10, 8'h01, 8'h00, 1'b0, 0, "rstmid.acc");

        // WIDTH=16 sweep: STAGES=4 and STAGES=1 run side by side, exact latency
        for (int n = 0; n < 46; n++) begin
            @(negedge clk);
            idx = n - 4;
            if (idx >= 0 && idx < 40) begin
                check("s4.valid", 64'(out_valid_s4), 64'd1);
                check("s4.sum", 64'(sum_s4), sw_sum[idx]);
                check("s4.cout", 64'(cout_s4), 64'(sw_c[idx]));
                check("s4.ovf", 64'(ovf_s4), 64'(sw_o[idx]));
                check("s4.sat", 64'(sat_s4), 64'(sw_s[idx]));
            end else begin
                check("s4.idle", 64'(out_valid_s4), 64'd0);
            end
            idx = n - 1;
            if (idx >= 0 && idx < 40) begin
                check("s1.valid", 64'(out_valid_s1), 64'd1);
                check("s1.sum", 64'(sum_s1), sw_sum[idx]);
                check("s1.cout", 64'(cout_s1), 64'(sw_c[idx]));
                check("s1.ovf", 64'(ovf_s1), 64'(sw_o[idx]));
                check("s1.sat", 64'(sat_s1), 64'(sw_s[idx]));
            end else begin
                check("s1.idle", 64'(out_valid_s1), 64'd0);
            end
            if (n < 40) begin
                in_valid_w = 1'b1;
                op_w  = 2'($urandom_range(0, 1));
                a_w   = 16'($urandom);
                b_w   = 16'($urandom);
                cin_w = 1'($urandom);
                model(16, op_w, longint'(a_w), longint'(b_w), cin_w, 0,
                      sw_sum[n], sw_c[n], sw_o[n], sw_s[n]);
                #1 check("s4.ready", 64'(in_ready_s4), 64'd1);
                check("s1.ready", 64'(in_ready_s1), 64'd1);
            end else begin
                in_valid_w = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
